// File: rtl/array_pkg.sv
// Shared types and constants for the Eyeriss-style array sequencer.
package array_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WLOAD,
    S_MAC,
    S_DRAIN,
    S_FIN
  } seq_state_e;

  localparam int DEF_HEIGHT = 12;
  localparam int DEF_WIDTH  = 14;

  // Unary MAC length for an operand of the given width.
  function automatic int MACCYC_OF(input int iwidth);
    return 1 << (iwidth - 1);
  endfunction

endpackage

// File: rtl/array_seq_eyeriss_skew_win.sv
// Per-row MAC window decode: row BASE is active for MACCYC advancing
// cycles starting at cnt==BASE, and flags its last one.
module skew_win #(
  parameter int CW     = 8,
  parameter int MACCYC = 128,
  parameter int BASE   = 0
) (
  input  logic [CW-1:0] cnt_i,
  input  logic          adv_i,
  output logic          win_o,
  output logic          last_o
);

  localparam logic [CW:0] LO      = (CW+1)'(BASE);
  localparam logic [CW:0] LEN     = (CW+1)'(MACCYC);
  localparam logic [CW:0] LASTOFF = (CW+1)'(MACCYC - 1);

  logic [CW:0] off;

  // One extra bit keeps cnt<BASE wrapping to a value far above LEN.
  always_comb begin
    off    = {1'b0, cnt_i} - LO;
    win_o  = adv_i && (off < LEN);
    last_o = adv_i && (off == LASTOFF);
  end

endmodule

// File: rtl/array_seq_eyeriss.sv
// Tile sequencer for the PE array: clear, weight load, skewed MAC, drain.
module array_seq_eyeriss
  import array_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IWIDTH = 8,
  parameter int MACCYC = MACCYC_OF(IWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ifm_vld,
  output logic              ifm_rd,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [HEIGHT-1:0] mac_done,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(MACCYC + HEIGHT + 1);

  localparam logic [CW-1:0] WL_LAST  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0] MAC_LAST = CW'(MACCYC + HEIGHT - 2);
  localparam logic [CW-1:0] DR_LAST  = CW'(HEIGHT);
  localparam logic [CW-1:0] RD_LIM   = CW'(MACCYC);

  seq_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic              adv;
  logic [HEIGHT-1:0] win_d;
  logic [HEIGHT-1:0] last_d;

  logic              ifm_rd_q;
  logic [HEIGHT-1:0] en_i_q;
  logic [HEIGHT-1:0] clr_i_q;
  logic [HEIGHT-1:0] mac_done_q;
  logic [WIDTH-1:0]  en_w_q;
  logic [WIDTH-1:0]  clr_w_q;
  logic [WIDTH-1:0]  en_o_q;
  logic [WIDTH-1:0]  clr_o_q;
  logic              busy_q;
  logic              done_q;

  // MAC progresses only while the ifm buffer holds a column.
  always_comb adv = (state_q == S_MAC) && ifm_vld;

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    skew_win #(
      .CW     (CW),
      .MACCYC (MACCYC),
      .BASE   (h)
    ) u_win (
      .cnt_i  (cnt_q),
      .adv_i  (adv),
      .win_o  (win_d[h]),
      .last_o (last_d[h])
    );
  end

  // Sequencer FSM, tile counter and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ifm_rd_q   <= 1'b0;
      en_i_q     <= '0;
      clr_i_q    <= '0;
      mac_done_q <= '0;
      en_w_q     <= '0;
      clr_w_q    <= '0;
      en_o_q     <= '0;
      clr_o_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ifm_rd_q   <= adv && (cnt_q < RD_LIM);
      en_i_q     <= win_d;
      mac_done_q <= last_d;
      clr_i_q    <= {HEIGHT{state_q == S_CLR}};
      clr_w_q    <= {WIDTH{state_q == S_CLR}};
      clr_o_q    <= {WIDTH{state_q == S_CLR}};
      en_w_q     <= {WIDTH{state_q == S_WLOAD}};
      en_o_q     <= {WIDTH{state_q == S_DRAIN}};
      busy_q     <= (state_q != S_IDLE);
      done_q     <= (state_q == S_FIN);

      case (state_q)
        S_IDLE: if (start) state_q <= S_CLR;
        S_CLR: begin
          state_q <= S_WLOAD;
          cnt_q   <= '0;
        end
        S_WLOAD: begin
          if (cnt_q == WL_LAST) begin
            state_q <= S_MAC;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_MAC: begin
          if (ifm_vld) begin
            if (cnt_q == MAC_LAST) begin
              state_q <= S_DRAIN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == DR_LAST) begin
            state_q <= S_FIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ifm_rd   = ifm_rd_q;
    en_i     = en_i_q;
    clr_i    = clr_i_q;
    mac_done = mac_done_q;
    en_w     = en_w_q;
    clr_w    = clr_w_q;
    en_o     = en_o_q;
    clr_o    = clr_o_q;
    busy     = busy_q;
    done     = done_q;
  end

endmodule

// File: tb/tb_array_seq_eyeriss.sv
// Bench for array_seq_eyeriss: HEIGHT=4 and HEIGHT=1 instances share stimulus;
// a linear tile-position model predicts every output each cycle.
module tb_array_seq_eyeriss;

  localparam int M = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ifm_vld = 1'b0;

  logic       rd4, busy4, done4;
  logic [3:0] eni4, clri4, md4;
  logic [2:0] enw4, clrw4, eno4, clro4;
  logic       rd1, busy1, done1;
  logic [0:0] eni1, clri1, md1;
  logic [2:0] enw1, clrw1, eno1, clro1;

  array_seq_eyeriss #(.HEIGHT(4), .WIDTH(3), .IWIDTH(4), .MACCYC(8)) u4 (
    .clk(clk), .rst(rst), .start(start), .ifm_vld(ifm_vld), .ifm_rd(rd4),
    .en_i(eni4), .clr_i(clri4), .mac_done(md4), .en_w(enw4), .clr_w(clrw4),
    .en_o(eno4), .clr_o(clro4), .busy(busy4), .done(done4));

  array_seq_eyeriss #(.HEIGHT(1), .WIDTH(3), .IWIDTH(4), .MACCYC(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .ifm_vld(ifm_vld), .ifm_rd(rd1),
    .en_i(eni1), .clr_i(clri1), .mac_done(md1), .en_w(enw1), .clr_w(clrw1),
    .en_o(eno1), .clr_o(clro1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  logic [26:0] v4, v1;
  assign v4 = {rd4, eni4, clri4, md4, enw4, clrw4, eno4, clro4, busy4, done4};
  assign v1 = {rd1, 3'b0, eni1, 3'b0, clri1, 3'b0, md1, enw1, clrw1, eno1, clro1, busy1, done1};

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: q = -1 idle, otherwise position 0..3H+M+1 within the tile.
  function automatic logic [26:0] f(input int H, input int q, input logic vld);
    logic rd, bz, dn;
    logic [3:0] ei, ci, md;
    logic [2:0] ew, cw, eo, co;
    int k;
    rd = 0; bz = 0; dn = 0; ei = 0; ci = 0; md = 0; ew = 0; cw = 0; eo = 0; co = 0;
    if (q >= 0) begin
      bz = 1;
      k = q - 1 - H;
      if (q == 0) begin
        for (int h = 0; h < H; h++) ci[h] = 1'b1;
        cw = 3'b111; co = 3'b111;
      end
      if (q >= 1 && q <= H) ew = 3'b111;
      if (vld && k >= 0 && k <= M + H - 2) begin
        rd = (k < M);
        for (int h = 0; h < H; h++) begin
          ei[h] = (k >= h) && (k < h + M);
          md[h] = (k == h + M - 1);
        end
      end
      if (q >= M + 2*H && q <= M + 3*H) eo = 3'b111;
      dn = (q == M + 3*H + 1);
    end
    return {rd, ei, ci, md, ew, cw, eo, co, bz, dn};
  endfunction

  function automatic int nxt(input int H, input int q, input logic st, input logic vld);
    int k;
    if (q < 0) return st ? 0 : -1;
    k = q - 1 - H;
    if (k >= 0 && k <= M + H - 2 && !vld) return q;
    if (q == M + 3*H + 1) return -1;
    return q + 1;
  endfunction

  int q4 = -1, q1 = -1;
  logic [26:0] e4 = '0, e1 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q4 = -1; q1 = -1; e4 = '0; e1 = '0;
    end else begin
      e4 = f(4, q4, ifm_vld);
      e1 = f(1, q1, ifm_vld);
      q4 = nxt(4, q4, start, ifm_vld);
      q1 = nxt(1, q1, start, ifm_vld);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outs_h4", v4, e4);
      chk("outs_h1", v1, e1);
    end
  end

  // Per-tile event counters used for the literal expectations.
  int cyc_n = 0;
  int busy_c, rd_c, eno_c, done_c, eni0_c, enw_c, clr_c, e0_first, e3_first;
  int busy1_c, eni1_c, md1_c, done1_c, md4_c;
  int mdv[$];
  int mds[$];

  task automatic clear_mon();
    busy_c = 0; rd_c = 0; eno_c = 0; done_c = 0; eni0_c = 0; enw_c = 0; clr_c = 0;
    e0_first = -1; e3_first = -1; busy1_c = 0; eni1_c = 0; md1_c = 0; done1_c = 0;
    md4_c = 0; mdv.delete(); mds.delete();
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (busy4) busy_c++;
    if (rd4) rd_c++;
    if (eno4 == 3'b111) eno_c++;
    if (done4) done_c++;
    if (eni4[0]) eni0_c++;
    if (enw4 == 3'b111) enw_c++;
    if (clro4 == 3'b111 && clri4 == 4'hf && clrw4 == 3'b111) clr_c++;
    if (eni4[0] && e0_first < 0) e0_first = cyc_n;
    if (eni4[3] && e3_first < 0) e3_first = cyc_n;
    if (md4 != 0) begin mdv.push_back(int'(md4)); mds.push_back(cyc_n); md4_c++; end
    if (busy1) busy1_c++;
    if (eni1[0]) eni1_c++;
    if (md1[0]) md1_c++;
    if (done1) done1_c++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_q4(input int target);
    int n;
    n = 0;
    while (q4 != target && n < 200) begin cyc(); n++; end
    if (q4 != target) chk("wait_q4_timeout", q4, target);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q4 >= 0 || q1 >= 0) && n < 300) begin cyc(); n++; end
    if (q4 >= 0 || q1 >= 0) chk("wait_idle_timeout", q4, -1);
    cyc(); cyc();
  endtask

  initial begin
    clear_mon();
    #2 rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    chk_en = 1;

    // Reset then idle
    clear_mon();
    repeat (20) cyc();
    chk("idle_busy_cycles", busy_c, 0);
    chk("idle_outs", v4, 0);

    // Nominal tile
    ifm_vld = 1'b1;
    clear_mon();
    pulse_start();
    wait_idle();
    chk("nom_latency", busy_c, 22);
    chk("nom_clr_cycles", clr_c, 1);
    chk("nom_enw_cycles", enw_c, 4);
    chk("nom_eni0_cycles", eni0_c, 8);
    chk("nom_eni3_skew", e3_first - e0_first, 3);
    chk("nom_rd_cycles", rd_c, 8);
    chk("nom_eno_cycles", eno_c, 5);
    chk("nom_done", done_c, 1);
    chk("nom_md_count", mdv.size(), 4);
    if (mdv.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("nom_md_value", mdv[i], 1 << i);
        chk("nom_md_consec", mds[i] - mds[0], i);
      end
    end
    chk("h1_latency", busy1_c, 13);
    chk("h1_eni_cycles", eni1_c, 8);
    chk("h1_md", md1_c, 1);
    chk("h1_done", done1_c, 1);

    // Stall mid-MAC at cnt=5
    clear_mon();
    pulse_start();
    wait_q4(1 + 4 + 5);
    ifm_vld = 1'b0;
    repeat (3) cyc();
    ifm_vld = 1'b1;
    wait_idle();
    chk("stall_latency", busy_c, 25);
    chk("stall_rd_cycles", rd_c, 8);
    chk("stall_done", done_c, 1);

    // Stall on the terminal MAC cycle
    clear_mon();
    pulse_start();
    wait_q4(1 + 4 + 10);
    ifm_vld = 1'b0;
    repeat (4) cyc();
    ifm_vld = 1'b1;
    wait_idle();
    chk("term_latency", busy_c, 26);
    chk("term_md_count", md4_c, 4);
    chk("term_done", done_c, 1);

    // Reset mid-DRAIN
    clear_mon();
    pulse_start();
    wait_q4(M + 2*4 + 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_h4", v4, 0);
    chk("async_rst_h1", v1, 0);
    cyc(); cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("rst_no_done", done_c, 0);
    clear_mon();
    pulse_start();
    wait_idle();
    chk("post_rst_latency", busy_c, 22);
    chk("post_rst_done", done_c, 1);

    // Extra start pulses during MAC and FIN
    clear_mon();
    pulse_start();
    wait_q4(1 + 4 + 3);
    pulse_start();
    wait_q4(M + 3*4 + 1);
    pulse_start();
    wait_idle();
    chk("busy_start_done", done_c, 1);
    chk("busy_start_latency", busy_c, 22);

    // Randomized ifm_vld and start
    for (int n = 0; n < 600; n++) begin
      ifm_vld = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      cyc();
    end
    start = 1'b0;
    ifm_vld = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_seq_eyeriss.md
Name: array_seq_eyeriss

Overview:
- Control sequencer directly upstream of the Eyeriss-style unary-rate PE array.
- For one tile it generates all per-row controls (en_i, clr_i, mac_done) and per-column controls (en_w, clr_w, en_o, clr_o).
- One tile is: clear, weight load, row-skewed MAC window, output drain.
- Handshakes with the ifm buffer (stall on empty) and with the tile scheduler (start/done).

Parameters:
- HEIGHT, 12, array rows (ifm lanes)
- WIDTH, 14, array columns (weight/ofm lanes)
- IWIDTH, 8, operand width; sets unary MAC length
- MACCYC, 128, cycles per unary MAC per row (2^(IWIDTH-1))
- CW, $clog2(MACCYC+HEIGHT+1), internal counter width (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  tile start pulse; sampled only in IDLE
- ifm_vld  in  1  ifm buffer has the current column of HEIGHT operands
- ifm_rd  out  1  pop ifm buffer this cycle
- en_i  out  HEIGHT  per-row ifm enable
- clr_i  out  HEIGHT  per-row ifm clear
- mac_done  out  HEIGHT  per-row end-of-MAC pulse
- en_w  out  WIDTH  per-column weight shift enable
- clr_w  out  WIDTH  per-column weight clear
- en_o  out  WIDTH  per-column ofm shift enable
- clr_o  out  WIDTH  per-column ofm clear
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at tile end

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset: state=IDLE, cnt=0, all outputs 0. Reset mid-tile aborts immediately; no done pulse.
- All outputs are registered, so each output changes one cycle after its state/cnt condition.
- FSM states: IDLE, CLR, WLOAD, MAC, DRAIN, FIN.
- IDLE:
  - start=1 -> CLR.
  - start in any other state is ignored.
- CLR, 1 cycle:
  - clr_i, clr_w, clr_o all ones.
  - -> WLOAD with cnt=0.
- WLOAD, HEIGHT cycles:
  - en_w all ones.
  - -> MAC when cnt==HEIGHT-1; cnt then resets to 0.
- MAC, MACCYC+HEIGHT-1 advancing cycles:
  - stall = ~ifm_vld. When stalled: cnt holds, en_i=0, mac_done=0, ifm_rd=0.
  - When not stalled: en_i[h]=1 iff h <= cnt < h+MACCYC (1-cycle skew per row).
  - mac_done[h]=1 iff cnt==h+MACCYC-1 and not stalled.
  - ifm_rd=1 iff cnt<MACCYC and not stalled.
  - -> DRAIN when cnt==MACCYC+HEIGHT-2 and not stalled.
- DRAIN, HEIGHT+1 cycles:
  - en_o all ones; ofm shifts out of row 0.
  - -> FIN.
- FIN, 1 cycle:
  - done=1 (registered, so visible the cycle after FIN entry).
  - -> IDLE.
  - start arriving during FIN is dropped.
- busy is 0 only in IDLE.
- Per-column outputs are identical across columns; each is its own WIDTH-bit vector so a later revision can column-gate.
- cnt never wraps: its compare bound is below 2^CW. HEIGHT=1 is legal (no skew).
- Stall at the exact terminal MAC cycle: the transition waits for ifm_vld.
- Total tile latency without stalls: 1 + HEIGHT + (MACCYC+HEIGHT-1) + (HEIGHT+1) + 1 cycles.

Decomposition:
- Package array_pkg holds:
  - seq_state_e enum (6 states, 3-bit)
  - MACCYC_OF(IWIDTH) function
  - default HEIGHT/WIDTH constants
- One sub-module, skew_win: given cnt, base offset h and length MACCYC, produces the en_i[h] and mac_done[h] compares.
  - Instantiated HEIGHT times in a generate loop.
  - The FSM and counter stay in the top.

Test Plan (HEIGHT=4, WIDTH=3, MACCYC=8 unless noted):
- Reset then idle:
  - Stimulus: rst pulse, no start.
  - Required: all outputs 0 and busy=0 for 20 cycles.
- Nominal tile:
  - Stimulus: start at t0, ifm_vld=1.
  - Required: clr_* =1 for 1 cycle; en_w=3'b111 for 4 cycles; en_i[0] high for 8 cycles; en_i[3] rises 3 cycles after en_i[0]; mac_done=4'b0001,0010,0100,1000 on consecutive cycles; ifm_rd high for exactly 8 cycles; en_o high for 5 cycles; single done pulse.
  - Total latency 1+4+11+5+1=22 cycles.
- Stall mid-MAC:
  - Stimulus: drop ifm_vld for 3 cycles at MAC cnt=5.
  - Required: en_i=0 and ifm_rd=0 during the stall; sequence resumes at cnt=5; done delayed by exactly 3 cycles.
- Stall on the terminal MAC cycle:
  - Stimulus: ifm_vld=0 when cnt=10.
  - Required: no DRAIN entry and mac_done[3] withheld until ifm_vld returns.
- Reset mid-DRAIN:
  - Stimulus: assert rst during DRAIN.
  - Required: all outputs 0 asynchronously; no done pulse; a new start after reset runs a full tile.
- Start during busy plus HEIGHT=1 variant:
  - Stimulus: extra start pulses during MAC and during FIN.
  - Required: they are ignored; exactly one done pulse.
  - With HEIGHT=1: en_i high for 8 cycles, one mac_done pulse, latency 1+1+8+2+1=13 cycles.
